// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
// bus_req-style handshake: the master raises req with a stable payload; the transfer completes on the edge where ack is high.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ack);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ack);
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit: decodes RV32 loads/stores, runs one word bus transfer, extends the load result.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses through an ERR state instead of the bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        bus_timeout,
  output logic [1:0]  state_dbg,
  load_store_unit_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [1:0] ST_ERR  = 2'd3;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          is_load_q;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_load;
  logic        is_store;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ext;
  logic        unused_instr;

  assign op       = instr[6:0];
  assign f3       = instr[14:12];
  assign is_load  = (op == OP_LOAD)  && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_store = (op == OP_STORE) && (f3 inside {3'b000, 3'b001, 3'b010});
  assign unused_instr = &{1'b0, instr[31:15], instr[11:7]};

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                      ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign misalign_err = (state == ST_ERR);
  assign done         = (state == ST_DONE) || (state == ST_ERR);
`else
  assign misalign_err = 1'b0;
  assign done         = (state == ST_DONE);
`endif

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Narrow stores replicate their data across all lanes; the strobe selects the lane.
  always_comb begin
    strb_n  = 4'b0000;
    wdata_n = 32'h0;
    if (is_store) begin
      case (f3[1:0])
        2'b00: begin
          strb_n  = 4'b0001 << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        2'b01: begin
          strb_n  = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{store_data[15:0]}};
        end
        default: begin
          strb_n  = 4'b1111;
          wdata_n = store_data;
        end
      endcase
    end
  end

  assign lane_byte = bus.rdata[{off_q, 3'b000} +: 8];
  assign lane_half = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  ext = {24'h0, lane_byte};
      3'b101:  ext = {16'h0, lane_half};
      default: ext = bus.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      is_load_q   <= 1'b0;
      load_data   <= 32'h0;
      bus_timeout <= 1'b0;
      bus.req     <= 1'b0;
      bus.we      <= 1'b0;
      bus.addr    <= 32'h0;
      bus.wdata   <= 32'h0;
      bus.wstrb   <= 4'b0000;
    end else begin
      bus_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_load || is_store) begin
`ifdef LSU_MISALIGN_TRAP_EN
              if (misaligned) begin
                state     <= ST_ERR;
                load_data <= 32'h0;
              end else
`endif
              begin
                state     <= ST_REQ;
                wait_cnt  <= '0;
                f3_q      <= f3;
                off_q     <= addr[1:0];
                is_load_q <= is_load;
                bus.req   <= 1'b1;
                bus.we    <= is_store;
                bus.addr  <= {addr[31:2], 2'b00};
                bus.wdata <= wdata_n;
                bus.wstrb <= strb_n;
              end
            end else begin
              state     <= ST_DONE;
              load_data <= 32'h0;
            end
          end
        end
        ST_REQ: begin
          if (bus.ack) begin
            bus.req   <= 1'b0;
            load_data <= is_load_q ? ext : 32'h0;
            state     <= ST_DONE;
          end else if (wait_cnt == TMO_LAST) begin
            bus.req     <= 1'b0;
            bus_timeout <= 1'b1;
            load_data   <= 32'h0;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
